// File: rtl/opsel_pkg.sv
// Shared width helpers for the operand selector FIFO.
// The entry struct depends on the W/NSRC parameters of each instance, so it is declared in the
// top level from these helpers rather than here.
package opsel_pkg;

  // Width of the B-source select field; at least one bit even for a single source.
  function automatic int unsigned sel_w(input int unsigned nsrc);
    return (nsrc <= 2) ? 1 : $clog2(nsrc);
  endfunction

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Even parity bit over an operand pair: stored bit makes the total number of ones even.
  function automatic logic even_par(input logic [63:0] a, input logic [63:0] b);
    return ^{a, b};
  endfunction

endpackage

// File: rtl/opsel_fifo.sv
// Generic synchronous FIFO of entry structs with an occupancy count.
// count is the only source of full/empty; pointers wrap naturally because DEPTH is a power of 2.
module opsel_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CW    = 3,
  parameter type         entry_t = logic
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        wdata,
  input  logic          pop,
  output entry_t        rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt_q;
  logic            do_push;
  logic            do_pop;

  // Accept only when there is room / data; a full FIFO refuses a push even while popping.
  always_comb begin
    full    = (cnt_q == CW'(DEPTH));
    empty   = (cnt_q == '0);
    do_push = push && !full;
    do_pop  = pop && !empty;
    count   = cnt_q;
    rdata   = mem[rd_ptr];
  end

  // Pointer and occupancy update; reset discards all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (do_pop && !do_push) cnt_q <= cnt_q - CW'(1);
    end
  end

  // Storage array; contents are don't-care until written because reads are gated by count.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/operand_select_fifo.sv
// Operand selector with elastic buffering: captures A and one of NSRC B sources per beat and
// queues {A, B, sel} toward the ALU. Optional macro OPSEL_PARITY_EN adds per-entry parity and a
// registered par_err pulse on pop.
module operand_select_fifo
  import opsel_pkg::*;
#(
  parameter int unsigned  W     = 8,
  parameter int unsigned  NSRC  = 4,
  parameter int unsigned  DEPTH = 4,
  localparam int unsigned SW    = sel_w(NSRC),
  localparam int unsigned CW    = cnt_w(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    da,
  input  logic [NSRC*W-1:0] db_bus,
  input  logic [SW-1:0]   sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    dataa,
  output logic [W-1:0]    datab,
  output logic [SW-1:0]   out_sel,
  output logic [CW-1:0]   count,
`ifdef OPSEL_PARITY_EN
  output logic            par_err,
`endif
  output logic            sel_err
);

  typedef struct packed {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [SW-1:0] tag;
`ifdef OPSEL_PARITY_EN
    logic          par;
`endif
  } entry_t;

  logic          sel_bad;
  logic [W-1:0]  b_sel;
  entry_t        wentry;
  entry_t        head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          sel_err_q;

  // Source mux; an out-of-range select falls back to source 0 but keeps the raw tag.
  always_comb begin
    sel_bad = (32'(sel) >= NSRC);
    b_sel   = db_bus[0 +: W];
    if (!sel_bad) b_sel = db_bus[32'(sel) * W +: W];
    wentry     = '0;
    wentry.a   = da;
    wentry.b   = b_sel;
    wentry.tag = sel;
`ifdef OPSEL_PARITY_EN
    wentry.par = even_par(64'(da), 64'(b_sel));
`endif
  end

  // Handshakes; in_ready is a function of occupancy only.
  always_comb begin
    in_ready  = !full;
    out_valid = !empty;
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  opsel_fifo #(
    .DEPTH   (DEPTH),
    .CW      (CW),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wentry),
    .pop   (pop),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Head fields are forced to zero whenever nothing is valid.
  always_comb begin
    dataa   = out_valid ? head.a   : '0;
    datab   = out_valid ? head.b   : '0;
    out_sel = out_valid ? head.tag : '0;
    sel_err = sel_err_q;
  end

  // Sticky flag for any accepted beat carrying an illegal select.
  always_ff @(posedge clk) begin
    if (rst)                  sel_err_q <= 1'b0;
    else if (push && sel_bad) sel_err_q <= 1'b1;
  end

`ifdef OPSEL_PARITY_EN
  // One-cycle pulse after a pop whose head no longer matches its stored parity.
  always_ff @(posedge clk) begin
    if (rst) par_err <= 1'b0;
    else     par_err <= pop && (even_par(64'(head.a), 64'(head.b)) != head.par);
  end
`endif

endmodule

// File: tb/tb_operand_select_fifo.sv
// Directed bench for operand_select_fifo: a W=8/NSRC=4/DEPTH=4 instance for the main
// behaviour and an NSRC=3 instance for the illegal-select case.
module tb_operand_select_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [7:0]  da;
  logic [31:0] db_bus;
  logic [1:0]  sel;
  logic        in_ready, out_valid, sel_err;
  logic [7:0]  dataa, datab;
  logic [1:0]  out_sel;
  logic [2:0]  count;

  logic        in_valid3, out_ready3;
  logic [1:0]  sel3;
  logic        in_ready3, out_valid3, sel_err3;
  logic [7:0]  dataa3, datab3;
  logic [1:0]  out_sel3;
  logic [2:0]  count3;

`ifdef OPSEL_PARITY_EN
  logic        par_err, par_err3;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_select_fifo #(.W(8), .NSRC(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .da        (da),
    .db_bus    (db_bus),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dataa     (dataa),
    .datab     (datab),
    .out_sel   (out_sel),
    .count     (count),
`ifdef OPSEL_PARITY_EN
    .par_err   (par_err),
`endif
    .sel_err   (sel_err)
  );

  operand_select_fifo #(.W(8), .NSRC(3), .DEPTH(4)) dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .da        (da),
    .db_bus    (db_bus[23:0]),
    .sel       (sel3),
    .out_valid (out_valid3),
    .out_ready (out_ready3),
    .dataa     (dataa3),
    .datab     (datab3),
    .out_sel   (out_sel3),
    .count     (count3),
`ifdef OPSEL_PARITY_EN
    .par_err   (par_err3),
`endif
    .sel_err   (sel_err3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; da = '0; sel = '0;
    db_bus = 32'h4433CCBB;
    in_valid3 = 1'b0; out_ready3 = 1'b0; sel3 = '0;

    // Reset
    tick(); tick();
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_count",     32'(count),     0);
    check("rst_in_ready",  32'(in_ready),  1);
    check("rst_dataa",     32'(dataa),     0);
    check("rst_datab",     32'(datab),     0);
    check("rst_sel_err",   32'(sel_err),   0);

    // Source selection, one-cycle latency
    da = 8'hAA; sel = 2'd0; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    check("s0_valid", 32'(out_valid), 1);
    check("s0_dataa", 32'(dataa),     32'hAA);
    check("s0_datab", 32'(datab),     32'hBB);
    check("s0_count", 32'(count),     1);
    sel = 2'd1;
    tick();
    check("s1_count",   32'(count),   1);
    check("s1_datab",   32'(datab),   32'hCC);
    check("s1_out_sel", 32'(out_sel), 1);
    in_valid = 1'b0;
    tick();
    check("drain_valid", 32'(out_valid), 0);
    check("drain_dataa", 32'(dataa),     0);

    // Fill to full, overflow beat ignored, ordered drain
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd2;
    for (int i = 1; i <= 4; i++) begin
      da = 8'(i);
      tick();
    end
    check("full_count",    32'(count),    4);
    check("full_in_ready", 32'(in_ready), 0);
    da = 8'h05;
    tick();
    check("ovf_count", 32'(count), 4);
    in_valid = 1'b0; out_ready = 1'b1;
    check("fill_datab", 32'(datab), 32'h33);
    for (int i = 1; i <= 4; i++) begin
      check("order_dataa", 32'(dataa), 32'(i));
      tick();
    end
    check("empty_valid", 32'(out_valid), 0);
    check("empty_count", 32'(count),     0);

    // Steady state at count 2 with wrap
    out_ready = 1'b0; in_valid = 1'b1; sel = 2'd3;
    da = 8'h10; tick();
    da = 8'h11; tick();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("steady_head", 32'(dataa), 32'h10 + 32'(i));
      da = 8'h12 + 8'(i);
      tick();
      check("steady_count", 32'(count), 2);
    end
    in_valid = 1'b0;
    check("tail_head0", 32'(dataa), 32'h1A);
    check("tail_datab", 32'(datab), 32'h44);
    tick();
    check("tail_head1", 32'(dataa), 32'h1B);
    tick();
    check("tail_empty", 32'(out_valid), 0);

    // Illegal select on the NSRC=3 instance
    da = 8'h5A; sel3 = 2'd3; in_valid3 = 1'b1;
    tick();
    in_valid3 = 1'b0;
    check("ill_datab",   32'(datab3),   32'hBB);
    check("ill_out_sel", 32'(out_sel3), 3);
    check("ill_sel_err", 32'(sel_err3), 1);
    check("ill_dataa",   32'(dataa3),   32'h5A);
    out_ready3 = 1'b1;
    tick();
    check("ill_sticky", 32'(sel_err3),   1);
    check("ill_popped", 32'(out_valid3), 0);

    // Mid-operation reset with three entries queued
    out_ready = 1'b0; in_valid = 1'b1;
    tick(); tick(); tick();
    in_valid = 1'b0;
    check("pre_rst_count", 32'(count), 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count",   32'(count),    0);
    check("mid_rst_valid",   32'(out_valid), 0);
    check("mid_rst_sel_err", 32'(sel_err3), 0);

`ifdef OPSEL_PARITY_EN
    // Corrupt the stored entry and expect a parity pulse after its pop
    da = 8'h3C; sel = 2'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    dut.u_fifo.mem[0].a[0] = ~dut.u_fifo.mem[0].a[0];
    out_ready = 1'b1;
    check("par_idle", 32'(par_err), 0);
    tick();
    check("par_pulse", 32'(par_err), 1);
    tick();
    check("par_clear", 32'(par_err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
